// File: rtl/ace_ccu_snoop_responder.sv
// Cache-side snoop endpoint: accepts AC snoops, looks up line state, answers on CR,
// streams the line on CD when data moves, then applies invalidate/clean to the line.

package ace_ccu_snoop_pkg;
  localparam int unsigned AddrWidth = 64;
  localparam int unsigned DataWidth = 64;

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic [3:0]           snoop;
    logic [2:0]           prot;
  } ac_chan_t;

  typedef struct packed {
    logic was_unique;
    logic is_shared;
    logic pass_dirty;
    logic error;
    logic data_transfer;
  } cr_chan_t;

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic                 last;
  } cd_chan_t;

  typedef struct packed {
    logic     ac_valid;
    ac_chan_t ac;
    logic     cr_ready;
    logic     cd_ready;
  } snoop_req_t;

  typedef struct packed {
    logic     ac_ready;
    logic     cr_valid;
    cr_chan_t cr_resp;
    logic     cd_valid;
    cd_chan_t cd;
  } snoop_resp_t;
endpackage

module ace_ccu_snoop_responder #(
  parameter int unsigned DataWidth = 64,
  parameter int unsigned LineBytes = 64,
  parameter int unsigned AddrWidth = 64,
  parameter type ac_chan_t    = ace_ccu_snoop_pkg::ac_chan_t,
  parameter type cr_chan_t    = ace_ccu_snoop_pkg::cr_chan_t,
  parameter type cd_chan_t    = ace_ccu_snoop_pkg::cd_chan_t,
  parameter type snoop_req_t  = ace_ccu_snoop_pkg::snoop_req_t,
  parameter type snoop_resp_t = ace_ccu_snoop_pkg::snoop_resp_t
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  snoop_req_t           snoop_req_i,
  output snoop_resp_t          snoop_resp_o,
  output logic                 lu_valid_o,
  input  logic                 lu_ready_i,
  output logic [AddrWidth-1:0] lu_addr_o,
  input  logic                 lu_rsp_valid_i,
  input  logic                 lu_hit_i,
  input  logic                 lu_dirty_i,
  input  logic                 lu_shared_i,
  output logic                 rd_valid_o,
  input  logic                 rd_ready_i,
  input  logic                 rd_data_valid_i,
  output logic                 rd_data_ready_o,
  input  logic [DataWidth-1:0] rd_data_i,
  output logic                 upd_valid_o,
  input  logic                 upd_ready_i,
  output logic                 upd_inval_o,
  output logic                 upd_clean_o
);

  localparam int unsigned Beats  = LineBytes / (DataWidth / 8);
  localparam int unsigned BeatW  = $clog2(Beats);
  localparam int unsigned OffW   = $clog2(LineBytes);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LOOKUP  = 3'd1;
  localparam logic [2:0] WAIT_LU = 3'd2;
  localparam logic [2:0] RESP    = 3'd3;
  localparam logic [2:0] DATA    = 3'd4;
  localparam logic [2:0] UPDATE  = 3'd5;

  localparam logic [3:0] ReadOnce           = 4'b0000;
  localparam logic [3:0] ReadShared         = 4'b0001;
  localparam logic [3:0] ReadClean          = 4'b0010;
  localparam logic [3:0] ReadNotSharedDirty = 4'b0011;
  localparam logic [3:0] ReadUnique         = 4'b0111;
  localparam logic [3:0] CleanShared        = 4'b1000;
  localparam logic [3:0] CleanInvalid       = 4'b1001;
  localparam logic [3:0] MakeInvalid        = 4'b1101;

  logic [2:0]           state_q, state_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [3:0]           snoop_q, snoop_d;
  cr_chan_t             cr_q, cr_d;
  logic                 inval_q, inval_d;
  logic                 clean_q, clean_d;
  logic                 cr_done_q, cr_done_d;
  logic                 rd_done_q, rd_done_d;
  logic [BeatW-1:0]     beat_q, beat_d;
  logic                 ac_ready_q, ac_ready_d;
  logic                 lu_valid_q, lu_valid_d;
  logic                 cr_valid_q, cr_valid_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 upd_valid_q, upd_valid_d;
  logic                 upd_inval_q, upd_inval_d;
  logic                 upd_clean_q, upd_clean_d;

  logic ty_read_c, ty_clean_c, ty_inv_c, ty_known_c;
  logic hit_c, dt_c, pd_c, inv_c;
  logic in_data_c, cd_hs_c, cd_last_c;
  logic unused_c;

  // Snoop-type classification; anything not listed behaves like a miss.
  assign ty_read_c  = (snoop_q == ReadOnce) || (snoop_q == ReadShared) || (snoop_q == ReadClean) ||
                      (snoop_q == ReadNotSharedDirty) || (snoop_q == ReadUnique);
  assign ty_clean_c = (snoop_q == CleanShared) || (snoop_q == CleanInvalid);
  assign ty_inv_c   = (snoop_q == ReadUnique) || (snoop_q == CleanInvalid) || (snoop_q == MakeInvalid);
  assign ty_known_c = ty_read_c || ty_clean_c || (snoop_q == MakeInvalid);

  assign hit_c = lu_hit_i & ty_known_c;
  assign dt_c  = (hit_c & ty_read_c) | (hit_c & lu_dirty_i & ty_clean_c);
  assign pd_c  = dt_c & lu_dirty_i & (snoop_q != ReadOnce);
  assign inv_c = hit_c & ty_inv_c;

  assign in_data_c = (state_q == DATA);
  assign cd_hs_c   = in_data_c & rd_data_valid_i & snoop_req_i.cd_ready;
  assign cd_last_c = (beat_q == BeatW'(Beats - 1));

  assign unused_c = ^{snoop_req_i.ac.prot, snoop_req_i.ac.addr[OffW-1:0]};

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    snoop_d   = snoop_q;
    cr_d      = cr_q;
    inval_d   = inval_q;
    clean_d   = clean_q;
    cr_done_d = cr_done_q;
    rd_done_d = rd_done_q;
    beat_d    = beat_q;

    case (state_q)
      IDLE: begin
        if (snoop_req_i.ac_valid && ac_ready_q) begin
          addr_d  = {snoop_req_i.ac.addr[AddrWidth-1:OffW], OffW'(0)};
          snoop_d = snoop_req_i.ac.snoop;
          cr_d    = '0;
          inval_d = 1'b0;
          clean_d = 1'b0;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (lu_ready_i) state_d = WAIT_LU;
      end
      WAIT_LU: begin
        if (lu_rsp_valid_i) begin
          cr_d.was_unique    = hit_c & ~lu_shared_i;
          cr_d.is_shared     = hit_c & ~inv_c;
          cr_d.pass_dirty    = pd_c;
          cr_d.error         = 1'b0;
          cr_d.data_transfer = dt_c;
          inval_d   = inv_c;
          clean_d   = pd_c;
          cr_done_d = 1'b0;
          rd_done_d = ~dt_c;
          state_d   = RESP;
        end
      end
      // CR and the line read complete independently; data only flows once both are done.
      RESP: begin
        cr_done_d = cr_done_q | (cr_valid_q & snoop_req_i.cr_ready);
        rd_done_d = rd_done_q | (rd_valid_q & rd_ready_i);
        if (cr_done_d && rd_done_d) begin
          if (cr_q.data_transfer)      state_d = DATA;
          else if (inval_q || clean_q) state_d = UPDATE;
          else                         state_d = IDLE;
        end
      end
      DATA: begin
        if (cd_hs_c) begin
          beat_d = beat_q + BeatW'(1);
          if (cd_last_c) state_d = (inval_q || clean_q) ? UPDATE : IDLE;
        end
      end
      UPDATE: begin
        if (upd_valid_q && upd_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    ac_ready_d  = (state_d == IDLE);
    lu_valid_d  = (state_d == LOOKUP);
    cr_valid_d  = (state_d == RESP) & ~cr_done_d;
    rd_valid_d  = (state_d == RESP) & ~rd_done_d;
    upd_valid_d = (state_d == UPDATE);
    upd_inval_d = upd_valid_d & inval_d;
    upd_clean_d = upd_valid_d & clean_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      snoop_q     <= '0;
      cr_q        <= '0;
      inval_q     <= 1'b0;
      clean_q     <= 1'b0;
      cr_done_q   <= 1'b0;
      rd_done_q   <= 1'b0;
      beat_q      <= '0;
      ac_ready_q  <= 1'b0;
      lu_valid_q  <= 1'b0;
      cr_valid_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      upd_valid_q <= 1'b0;
      upd_inval_q <= 1'b0;
      upd_clean_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      snoop_q     <= snoop_d;
      cr_q        <= cr_d;
      inval_q     <= inval_d;
      clean_q     <= clean_d;
      cr_done_q   <= cr_done_d;
      rd_done_q   <= rd_done_d;
      beat_q      <= beat_d;
      ac_ready_q  <= ac_ready_d;
      lu_valid_q  <= lu_valid_d;
      cr_valid_q  <= cr_valid_d;
      rd_valid_q  <= rd_valid_d;
      upd_valid_q <= upd_valid_d;
      upd_inval_q <= upd_inval_d;
      upd_clean_q <= upd_clean_d;
    end
  end

  // CD is a straight pass-through of the read stream while in DATA.
  always_comb begin
    snoop_resp_o          = '0;
    snoop_resp_o.ac_ready = ac_ready_q;
    snoop_resp_o.cr_valid = cr_valid_q;
    snoop_resp_o.cr_resp  = cr_q;
    snoop_resp_o.cd_valid = in_data_c & rd_data_valid_i;
    snoop_resp_o.cd.data  = in_data_c ? rd_data_i : '0;
    snoop_resp_o.cd.last  = in_data_c & cd_last_c;
  end

  assign lu_valid_o      = lu_valid_q;
  assign lu_addr_o       = addr_q;
  assign rd_valid_o      = rd_valid_q;
  assign rd_data_ready_o = in_data_c & snoop_req_i.cd_ready;
  assign upd_valid_o     = upd_valid_q;
  assign upd_inval_o     = upd_inval_q;
  assign upd_clean_o     = upd_clean_q;

endmodule

// File: tb/tb_ace_ccu_snoop_responder.sv
// Directed bench for ace_ccu_snoop_responder: vector table of snoop/line-state cases
// plus backpressure and mid-data reset sequences.

module tb_ace_ccu_snoop_responder;
  import ace_ccu_snoop_pkg::*;

  localparam int BeatsI = 8;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        ac_valid = 1'b0;
  ac_chan_t    ac = '0;
  logic        cr_ready, cd_ready;
  snoop_req_t  req;
  snoop_resp_t resp;
  assign req = {ac_valid, ac, cr_ready, cd_ready};

  logic        lu_valid_o, lu_ready_i, lu_rsp_valid_i, lu_hit_i, lu_dirty_i, lu_shared_i;
  logic [63:0] lu_addr_o;
  logic        rd_valid_o, rd_ready_i, rd_data_valid_i, rd_data_ready_o;
  logic [63:0] rd_data_i;
  logic        upd_valid_o, upd_ready_i, upd_inval_o, upd_clean_o;

  ace_ccu_snoop_responder #(.DataWidth(64), .LineBytes(64), .AddrWidth(64)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .snoop_req_i(req), .snoop_resp_o(resp),
    .lu_valid_o(lu_valid_o), .lu_ready_i(lu_ready_i), .lu_addr_o(lu_addr_o),
    .lu_rsp_valid_i(lu_rsp_valid_i), .lu_hit_i(lu_hit_i), .lu_dirty_i(lu_dirty_i),
    .lu_shared_i(lu_shared_i), .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i),
    .rd_data_valid_i(rd_data_valid_i), .rd_data_ready_o(rd_data_ready_o), .rd_data_i(rd_data_i),
    .upd_valid_o(upd_valid_o), .upd_ready_i(upd_ready_i), .upd_inval_o(upd_inval_o),
    .upd_clean_o(upd_clean_o)
  );

  // Configuration owned by the main sequence
  logic        cfg_hit = 1'b0, cfg_dirty = 1'b0, cfg_shared = 1'b0;
  int          cfg_stall = 0;
  bit          cfg_toggle = 1'b0;
  logic [31:0] snoop_id = 32'h0;

  // Observations owned by the agent
  int          cr_cnt, cd_cnt, cd_last_cnt, data_err, upd_cnt, rd_cnt, stab_err, stall_cycles;
  logic [4:0]  cr_seen;
  logic        upd_inval_seen, upd_clean_seen;
  logic [63:0] lu_addr_seen;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [63:0] beat_pat(input logic [31:0] id, input int idx);
    return {id, 32'(idx)};
  endfunction

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Cache-side agent: lookup responder, line-read source, CR/CD/UPD monitors
  initial begin : agent
    bit          lu_fire, start_src, rd_hs, src_active, cr_hold;
    int          src_idx, cd_idx, stall_left;
    logic [4:0]  cr_held;
    lu_fire = 0; start_src = 0; rd_hs = 0; src_active = 0; cr_hold = 0;
    src_idx = 0; cd_idx = 0; stall_left = 0; cr_held = '0;
    cr_cnt = 0; cd_cnt = 0; cd_last_cnt = 0; data_err = 0; upd_cnt = 0; rd_cnt = 0;
    stab_err = 0; stall_cycles = 0; cr_seen = '0; upd_inval_seen = 0; upd_clean_seen = 0;
    lu_addr_seen = '0;
    lu_ready_i = 1'b1; lu_rsp_valid_i = 1'b0; lu_hit_i = 1'b0; lu_dirty_i = 1'b0; lu_shared_i = 1'b0;
    rd_ready_i = 1'b1; rd_data_valid_i = 1'b0; rd_data_i = '0; upd_ready_i = 1'b1;
    cr_ready = 1'b1; cd_ready = 1'b1;
    forever begin
      @(negedge clk_i);
      lu_fire = 0; start_src = 0; rd_hs = 0;
      if (!rst_ni) begin
        src_active = 0; stall_left = 0; cr_hold = 0;
      end else begin
        lu_fire = lu_valid_o & lu_ready_i;
        if (lu_fire) begin
          lu_addr_seen = lu_addr_o;
          stall_left   = cfg_stall;
        end
        if (resp.cr_valid) begin
          if (cr_hold && (resp.cr_resp !== cr_held)) stab_err++;
          if (cr_ready) begin
            cr_cnt++; cr_seen = resp.cr_resp; cr_hold = 0;
          end else begin
            cr_hold = 1; cr_held = resp.cr_resp; stall_cycles++;
            if (stall_left > 0) stall_left--;
          end
        end
        if (rd_valid_o & rd_ready_i) begin
          rd_cnt++; start_src = 1;
        end
        if (resp.cd_valid & cd_ready) begin
          if ((resp.cd.data !== beat_pat(snoop_id, cd_idx)) || (resp.cd.last !== (cd_idx == BeatsI - 1)))
            data_err++;
          if (resp.cd.last) cd_last_cnt++;
          cd_cnt++; cd_idx++;
        end
        rd_hs = rd_data_valid_i & rd_data_ready_o;
        if (upd_valid_o & upd_ready_i) begin
          upd_cnt++; upd_inval_seen = upd_inval_o; upd_clean_seen = upd_clean_o;
        end
      end
      @(posedge clk_i); #1;
      lu_rsp_valid_i = lu_fire;
      lu_hit_i = cfg_hit; lu_dirty_i = cfg_dirty; lu_shared_i = cfg_shared;
      if (rd_hs) begin
        src_idx++;
        if (src_idx == BeatsI) src_active = 0;
      end
      if (start_src) begin
        src_active = 1; src_idx = 0; cd_idx = 0;
      end
      rd_data_valid_i = src_active;
      rd_data_i = src_active ? beat_pat(snoop_id, src_idx) : '0;
      cr_ready = (stall_left == 0);
      cd_ready = cfg_toggle ? ~cd_ready : 1'b1;
    end
  end

  task automatic issue(input logic [63:0] a, input logic [3:0] t);
    bit got;
    got = 0;
    @(posedge clk_i); #1;
    ac_valid = 1'b1; ac.addr = a; ac.snoop = t; ac.prot = 3'b010;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk_i);
      if (resp.ac_ready) begin got = 1; break; end
    end
    check("ac_accept", 128'(got), 128'(1));
    @(posedge clk_i); #1;
    ac_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit got;
    got = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk_i); #1;
      if (resp.ac_ready) begin got = 1; break; end
    end
    check("back_to_idle", 128'(got), 128'(1));
  endtask

  typedef struct {
    logic [3:0]  snoop;
    logic        hit, dirty, shared;
    logic [63:0] addr;
    logic [63:0] lu_addr;
    logic [4:0]  cr;
    int          beats;
    int          upd;
    logic        inval, clean;
  } vec_t;

  vec_t vecs[11];

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int s_cr, s_cd, s_last, s_err, s_upd, s_rd, s_stab, s_stall;
    bit got;

    vecs[0]  = '{4'b0001, 1'b0, 1'b0, 1'b0, 64'h0000_0000_0000_1040, 64'h0000_0000_0000_1040, 5'b00000, 0, 0, 1'b0, 1'b0};
    vecs[1]  = '{4'b0001, 1'b1, 1'b0, 1'b0, 64'h0000_0002_0000_1234, 64'h0000_0002_0000_1200, 5'b11001, 8, 0, 1'b0, 1'b0};
    vecs[2]  = '{4'b0111, 1'b1, 1'b1, 1'b0, 64'h0000_0000_0000_2078, 64'h0000_0000_0000_2040, 5'b10101, 8, 1, 1'b1, 1'b1};
    vecs[3]  = '{4'b1101, 1'b1, 1'b1, 1'b1, 64'h0000_0000_0000_3000, 64'h0000_0000_0000_3000, 5'b00000, 0, 1, 1'b1, 1'b0};
    vecs[4]  = '{4'b1000, 1'b1, 1'b0, 1'b0, 64'h0000_0000_0000_30C1, 64'h0000_0000_0000_30C0, 5'b11000, 0, 0, 1'b0, 1'b0};
    vecs[5]  = '{4'b0000, 1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFC0, 5'b01001, 8, 0, 1'b0, 1'b0};
    vecs[6]  = '{4'b1001, 1'b1, 1'b1, 1'b0, 64'h0000_0000_0000_4010, 64'h0000_0000_0000_4000, 5'b10101, 8, 1, 1'b1, 1'b1};
    vecs[7]  = '{4'b0010, 1'b1, 1'b1, 1'b1, 64'h0000_0000_0000_5080, 64'h0000_0000_0000_5080, 5'b01101, 8, 1, 1'b0, 1'b1};
    vecs[8]  = '{4'b0100, 1'b1, 1'b1, 1'b0, 64'h0000_0000_0000_6000, 64'h0000_0000_0000_6000, 5'b00000, 0, 0, 1'b0, 1'b0};
    vecs[9]  = '{4'b1000, 1'b1, 1'b1, 1'b1, 64'h0000_0000_0000_7FFF, 64'h0000_0000_0000_7FC0, 5'b01101, 8, 1, 1'b0, 1'b1};
    vecs[10] = '{4'b0011, 1'b0, 1'b1, 1'b0, 64'h0000_0000_0000_8000, 64'h0000_0000_0000_8000, 5'b00000, 0, 0, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(negedge clk_i);
    check("rst_resp", 128'(resp), 128'(0));
    check("rst_ctl", 128'({lu_valid_o, rd_valid_o, rd_data_ready_o, upd_valid_o, upd_inval_o, upd_clean_o, lu_addr_o}), 128'(0));
    #1 rst_ni = 1'b1;
    @(negedge clk_i); #1;
    check("ac_ready_after_reset", 128'(resp.ac_ready), 128'(1));

    foreach (vecs[i]) begin
      cfg_hit = vecs[i].hit; cfg_dirty = vecs[i].dirty; cfg_shared = vecs[i].shared;
      snoop_id = 32'hA000_0000 + 32'(i);
      s_cr = cr_cnt; s_cd = cd_cnt; s_last = cd_last_cnt; s_err = data_err; s_upd = upd_cnt; s_rd = rd_cnt;
      issue(vecs[i].addr, vecs[i].snoop);
      wait_idle();
      check($sformatf("v%0d_lu_addr", i), 128'(lu_addr_seen), 128'(vecs[i].lu_addr));
      check($sformatf("v%0d_cr_count", i), 128'(cr_cnt - s_cr), 128'(1));
      check($sformatf("v%0d_cr", i), 128'(cr_seen), 128'(vecs[i].cr));
      check($sformatf("v%0d_rd_reqs", i), 128'(rd_cnt - s_rd), 128'(vecs[i].beats > 0 ? 1 : 0));
      check($sformatf("v%0d_beats", i), 128'(cd_cnt - s_cd), 128'(vecs[i].beats));
      check($sformatf("v%0d_last", i), 128'(cd_last_cnt - s_last), 128'(vecs[i].beats > 0 ? 1 : 0));
      check($sformatf("v%0d_data", i), 128'(data_err - s_err), 128'(0));
      check($sformatf("v%0d_upd_count", i), 128'(upd_cnt - s_upd), 128'(vecs[i].upd));
      if (vecs[i].upd > 0)
        check($sformatf("v%0d_upd_flags", i), 128'({upd_inval_seen, upd_clean_seen}),
              128'({vecs[i].inval, vecs[i].clean}));
    end

    // Backpressure: CR stalled 10 cycles, CD ready toggling, two back-to-back line transfers
    cfg_stall = 10; cfg_toggle = 1'b1;
    cfg_hit = 1'b1; cfg_dirty = 1'b1; cfg_shared = 1'b0;
    for (int k = 0; k < 2; k++) begin
      snoop_id = 32'hB000_0000 + 32'(k);
      s_cr = cr_cnt; s_cd = cd_cnt; s_last = cd_last_cnt; s_err = data_err; s_upd = upd_cnt;
      s_stab = stab_err; s_stall = stall_cycles;
      issue(64'h0000_0000_0009_0000 + 64'(k) * 64'h40, 4'b0111);
      wait_idle();
      check($sformatf("bp%0d_cr", k), 128'(cr_seen), 128'(5'b10101));
      check($sformatf("bp%0d_cr_count", k), 128'(cr_cnt - s_cr), 128'(1));
      check($sformatf("bp%0d_cr_stable", k), 128'(stab_err - s_stab), 128'(0));
      check($sformatf("bp%0d_stall_cycles", k), 128'(stall_cycles - s_stall), 128'(10));
      check($sformatf("bp%0d_beats", k), 128'(cd_cnt - s_cd), 128'(8));
      check($sformatf("bp%0d_last", k), 128'(cd_last_cnt - s_last), 128'(1));
      check($sformatf("bp%0d_data", k), 128'(data_err - s_err), 128'(0));
      check($sformatf("bp%0d_upd", k), 128'({upd_cnt - s_upd, upd_inval_seen, upd_clean_seen}),
            128'({32'd1, 1'b1, 1'b1}));
    end
    cfg_stall = 0; cfg_toggle = 1'b0;

    // Reset in the middle of the CD burst
    cfg_hit = 1'b1; cfg_dirty = 1'b1; cfg_shared = 1'b0;
    snoop_id = 32'hC000_0000;
    s_cd = cd_cnt; s_upd = upd_cnt;
    issue(64'h0000_0000_000A_0000, 4'b0001);
    got = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk_i); #1;
      if (cd_cnt - s_cd >= 3) begin got = 1; break; end
    end
    check("mid_reset_reached_data", 128'(got), 128'(1));
    rst_ni = 1'b0;
    #1;
    check("mid_reset_resp", 128'(resp), 128'(0));
    @(posedge clk_i); #1;
    check("mid_reset_resp_edge", 128'(resp), 128'(0));
    check("mid_reset_ctl_edge", 128'({lu_valid_o, rd_valid_o, rd_data_ready_o, upd_valid_o, upd_inval_o, upd_clean_o, lu_addr_o}), 128'(0));
    @(negedge clk_i); #1;
    rst_ni = 1'b1;
    s_cr = cr_cnt; s_cd = cd_cnt;
    repeat (6) @(negedge clk_i);
    #1;
    check("mid_reset_no_cr", 128'(cr_cnt - s_cr), 128'(0));
    check("mid_reset_no_cd", 128'(cd_cnt - s_cd), 128'(0));
    check("mid_reset_no_upd", 128'(upd_cnt - s_upd), 128'(0));
    check("mid_reset_idle", 128'(resp.ac_ready), 128'(1));

    snoop_id = 32'hC000_0001;
    s_cr = cr_cnt; s_cd = cd_cnt; s_last = cd_last_cnt; s_err = data_err; s_upd = upd_cnt;
    issue(64'h0000_0000_000B_0008, 4'b0111);
    wait_idle();
    check("post_reset_lu_addr", 128'(lu_addr_seen), 128'(64'h0000_0000_000B_0000));
    check("post_reset_cr", 128'({cr_cnt - s_cr, 3'b000, cr_seen}), 128'({32'd1, 8'b000_10101}));
    check("post_reset_beats", 128'(cd_cnt - s_cd), 128'(8));
    check("post_reset_last", 128'(cd_last_cnt - s_last), 128'(1));
    check("post_reset_data", 128'(data_err - s_err), 128'(0));
    check("post_reset_upd", 128'({upd_cnt - s_upd, upd_inval_seen, upd_clean_seen}),
          128'({32'd1, 1'b1, 1'b1}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
